// File: rtl/eth_rx_frame_filter.sv
// eth_rx_frame_filter
// Store-and-forward Ethernet receive filter. Each frame from the MAC is
// buffered whole. It is released to the decoder only once its last byte has
// arrived and the frame has passed these checks: destination MAC, MAC error
// strobe, minimum length and buffer space. Rejected frames are rewound out of
// the buffer, so the decoder never sees any part of them.
// Optional statistics outputs: define RX_FILTER_STATS_EN. When it is
// undefined, frames_passed, frames_dropped and overflow are tied to zero.
module eth_rx_frame_filter #(
   parameter logic [47:0] FPGA_MAC_ADDR   = 48'h5a0102030405,
   parameter int          BUF_ADDR_WIDTH  = 11,
   parameter int          MIN_FRAME_BYTES = 14
) (
   input  logic        gtx_clk_bufg,
   input  logic        gtx_reset,
   input  logic        promisc_en,
   input  logic [7:0]  s_axis_tdata,
   input  logic        s_axis_tvalid,
   input  logic        s_axis_tlast,
   input  logic        s_axis_tuser,
   output logic        s_axis_tready,
   output logic [7:0]  m_axis_tdata,
   output logic        m_axis_tvalid,
   output logic        m_axis_tlast,
   input  logic        m_axis_tready,
   output logic [15:0] frames_passed,
   output logic [15:0] frames_dropped,
   output logic        overflow
);

   localparam int AW    = BUF_ADDR_WIDTH;
   localparam int DEPTH = 1 << AW;

   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW:0]   CNT_ZERO = {(AW+1){1'b0}};
   localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0]   CNT_MAX  = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0]   MIN_CNT  = (AW+1)'(MIN_FRAME_BYTES);
   localparam logic [AW:0]   HDR_LEN  = (AW+1)'(3'd6);
   localparam logic [AW:0]   HDR_LAST = (AW+1)'(3'd5);

   typedef enum logic [2:0] {
      ST_SYNC = 3'd0,
      ST_IDLE = 3'd1,
      ST_HDR  = 3'd2,
      ST_BODY = 3'd3,
      ST_DROP = 3'd4
   } wr_state_t;

   // write side state
   wr_state_t     state_r, state_nx_s;
   logic [AW-1:0] wr_ptr_r, wr_ptr_nx_s;
   logic [AW-1:0] commit_ptr_r, commit_nx_s;
   logic [AW:0]   byte_cnt_r, cnt_nx_s;
   logic          bad_r, bad_nx_s;
   logic          uni_r, uni_nx_s;
   logic          bc_r, bc_nx_s;

   // per-beat evaluation
   logic          start_s;
   logic [AW:0]   cnt_cur_s;
   logic [AW:0]   beat_cnt_s;
   logic          uni_cur_s, bc_cur_s;
   logic          beat_bad_s, beat_uni_s, beat_bc_s, beat_good_s;
   logic          hdr_byte_s, hdr_last_s;
   logic [7:0]    mac_byte_s;
   logic [AW-1:0] free_s;
   logic          full_s;
   logic          wr_en_s;

   // buffer and read side
   logic [8:0]    mem [DEPTH];
   logic [8:0]    ram_q_r;
   logic          ram_vld_r;
   logic [AW-1:0] rd_ptr_r;
   logic          rd_avail_s, pop_s, rd_en_s;
   logic [1:0]    occ_s;
   logic          h_vld_r, h_last_r, t_vld_r, t_last_r;
   logic [7:0]    h_data_r, t_data_r;

   // the MAC cannot be back-pressured
   assign s_axis_tready = 1'b1;

   // Evaluate the current input beat against the frame accumulated so far
   always_comb begin
      start_s    = (state_r == ST_IDLE);
      cnt_cur_s  = start_s ? CNT_ZERO : byte_cnt_r;
      uni_cur_s  = start_s ? 1'b1 : uni_r;
      bc_cur_s   = start_s ? 1'b1 : bc_r;
      free_s     = rd_ptr_r - wr_ptr_r - PTR_ONE;
      full_s     = (free_s == {AW{1'b0}});
      hdr_byte_s = (cnt_cur_s < HDR_LEN);
      hdr_last_s = (cnt_cur_s == HDR_LAST);
      case (cnt_cur_s[2:0])
         3'd0:    mac_byte_s = FPGA_MAC_ADDR[47:40];
         3'd1:    mac_byte_s = FPGA_MAC_ADDR[39:32];
         3'd2:    mac_byte_s = FPGA_MAC_ADDR[31:24];
         3'd3:    mac_byte_s = FPGA_MAC_ADDR[23:16];
         3'd4:    mac_byte_s = FPGA_MAC_ADDR[15:8];
         3'd5:    mac_byte_s = FPGA_MAC_ADDR[7:0];
         default: mac_byte_s = 8'h00;
      endcase
      if (cnt_cur_s == CNT_MAX) begin
         beat_cnt_s = CNT_MAX;
      end else begin
         beat_cnt_s = cnt_cur_s + CNT_ONE;
      end
      beat_bad_s = (start_s ? 1'b0 : bad_r) | s_axis_tuser;
      if (hdr_byte_s) begin
         beat_uni_s = uni_cur_s & (s_axis_tdata == mac_byte_s);
         beat_bc_s  = bc_cur_s & (s_axis_tdata == 8'hFF);
      end else begin
         beat_uni_s = uni_cur_s;
         beat_bc_s  = bc_cur_s;
      end
      // only a frame that reached the body can be good; the MAC check is the BODY gate
      beat_good_s = (state_r == ST_BODY) && !beat_bad_s && !full_s &&
                    (beat_cnt_s >= MIN_CNT) && (beat_cnt_s < CNT_MAX);
   end

   // Write FSM: next state, buffer write, commit and rewind decisions
   always_comb begin
      state_nx_s  = state_r;
      wr_ptr_nx_s = wr_ptr_r;
      commit_nx_s = commit_ptr_r;
      cnt_nx_s    = byte_cnt_r;
      bad_nx_s    = bad_r;
      uni_nx_s    = uni_r;
      bc_nx_s     = bc_r;
      wr_en_s     = 1'b0;
      case (state_r)
         ST_SYNC: begin
            // wait for a gap so a frame cut by reset is not taken as a new one
            if (!s_axis_tvalid) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_SYNC;
            end
         end
         ST_IDLE, ST_HDR, ST_BODY: begin
            if (s_axis_tvalid) begin
               cnt_nx_s = beat_cnt_s;
               bad_nx_s = beat_bad_s;
               uni_nx_s = beat_uni_s;
               bc_nx_s  = beat_bc_s;
               if (!full_s) begin
                  wr_en_s     = 1'b1;
                  wr_ptr_nx_s = wr_ptr_r + PTR_ONE;
               end else begin
                  wr_en_s     = 1'b0;
               end
               if (s_axis_tlast) begin
                  state_nx_s = ST_IDLE;
                  if (beat_good_s) begin
                     commit_nx_s = wr_ptr_r + PTR_ONE;
                  end else begin
                     wr_ptr_nx_s = commit_ptr_r;
                  end
               end else if (full_s) begin
                  state_nx_s = ST_DROP;
               end else if (hdr_last_s) begin
                  if (beat_uni_s || beat_bc_s || promisc_en) begin
                     state_nx_s = ST_BODY;
                  end else begin
                     state_nx_s = ST_DROP;
                  end
               end else if (state_r == ST_BODY) begin
                  state_nx_s = ST_BODY;
               end else begin
                  state_nx_s = ST_HDR;
               end
            end else begin
               state_nx_s = state_r;
            end
         end
         ST_DROP: begin
            if (s_axis_tvalid && s_axis_tlast) begin
               state_nx_s  = ST_IDLE;
               wr_ptr_nx_s = commit_ptr_r;
            end else begin
               state_nx_s  = ST_DROP;
            end
         end
         default: begin
            state_nx_s = ST_SYNC;
         end
      endcase
   end

   // Write FSM state and frame bookkeeping registers
   always_ff @(posedge gtx_clk_bufg or posedge gtx_reset) begin
      if (gtx_reset) begin
         state_r      <= ST_SYNC;
         wr_ptr_r     <= {AW{1'b0}};
         commit_ptr_r <= {AW{1'b0}};
         byte_cnt_r   <= CNT_ZERO;
         bad_r        <= 1'b0;
         uni_r        <= 1'b0;
         bc_r         <= 1'b0;
      end else begin
         state_r      <= state_nx_s;
         wr_ptr_r     <= wr_ptr_nx_s;
         commit_ptr_r <= commit_nx_s;
         byte_cnt_r   <= cnt_nx_s;
         bad_r        <= bad_nx_s;
         uni_r        <= uni_nx_s;
         bc_r         <= bc_nx_s;
      end
   end

   // Frame buffer: {tlast, data} write port and registered read port
   always_ff @(posedge gtx_clk_bufg) begin
      if (wr_en_s) begin
         mem[wr_ptr_r] <= {s_axis_tlast, s_axis_tdata};
      end
      if (rd_en_s) begin
         ram_q_r <= mem[rd_ptr_r];
      end
   end

   // Read issue: fetch only committed bytes and only when the output stage can absorb them
   always_comb begin
      rd_avail_s = (rd_ptr_r != commit_ptr_r);
      pop_s      = h_vld_r & m_axis_tready;
      occ_s      = {1'b0, h_vld_r} + {1'b0, t_vld_r} + {1'b0, ram_vld_r} - {1'b0, pop_s};
      if (rd_avail_s && (occ_s <= 2'd1)) begin
         rd_en_s = 1'b1;
      end else begin
         rd_en_s = 1'b0;
      end
   end

   // Read pointer and 2-entry output stage (head drives the master port)
   always_ff @(posedge gtx_clk_bufg or posedge gtx_reset) begin
      if (gtx_reset) begin
         rd_ptr_r  <= {AW{1'b0}};
         ram_vld_r <= 1'b0;
         h_vld_r   <= 1'b0;
         h_data_r  <= 8'h00;
         h_last_r  <= 1'b0;
         t_vld_r   <= 1'b0;
         t_data_r  <= 8'h00;
         t_last_r  <= 1'b0;
      end else begin
         ram_vld_r <= rd_en_s;
         if (rd_en_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         if (!h_vld_r || pop_s) begin
            if (t_vld_r) begin
               h_vld_r  <= 1'b1;
               h_data_r <= t_data_r;
               h_last_r <= t_last_r;
               t_vld_r  <= ram_vld_r;
               if (ram_vld_r) begin
                  t_data_r <= ram_q_r[7:0];
                  t_last_r <= ram_q_r[8];
               end
            end else if (ram_vld_r) begin
               h_vld_r  <= 1'b1;
               h_data_r <= ram_q_r[7:0];
               h_last_r <= ram_q_r[8];
               t_vld_r  <= 1'b0;
            end else begin
               h_vld_r  <= 1'b0;
               t_vld_r  <= 1'b0;
            end
         end else if (ram_vld_r) begin
            t_vld_r  <= 1'b1;
            t_data_r <= ram_q_r[7:0];
            t_last_r <= ram_q_r[8];
         end
      end
   end

   assign m_axis_tvalid = h_vld_r;
   assign m_axis_tdata  = h_data_r;
   assign m_axis_tlast  = h_last_r;

`ifdef RX_FILTER_STATS_EN
   logic [15:0] passed_r, dropped_r;
   logic        ovf_flag_r, ovf_cause_r;
   logic        in_frame_s, pass_evt_s, drop_evt_s;

   assign in_frame_s = (state_r == ST_IDLE) || (state_r == ST_HDR) || (state_r == ST_BODY);
   assign pass_evt_s = s_axis_tvalid && s_axis_tlast && in_frame_s && beat_good_s;
   assign drop_evt_s = s_axis_tvalid && s_axis_tlast &&
                       ((in_frame_s && !beat_good_s) || (state_r == ST_DROP));

   // Frame statistics; the overflow cause is latched on the beat that left the frame states
   always_ff @(posedge gtx_clk_bufg or posedge gtx_reset) begin
      if (gtx_reset) begin
         passed_r    <= 16'd0;
         dropped_r   <= 16'd0;
         ovf_flag_r  <= 1'b0;
         ovf_cause_r <= 1'b0;
      end else begin
         if (s_axis_tvalid && in_frame_s) begin
            ovf_cause_r <= full_s;
         end
         if (pass_evt_s) begin
            passed_r <= passed_r + 16'd1;
         end
         if (drop_evt_s) begin
            dropped_r <= dropped_r + 16'd1;
            if ((state_r == ST_DROP) ? ovf_cause_r : full_s) begin
               ovf_flag_r <= 1'b1;
            end
         end
      end
   end

   assign frames_passed  = passed_r;
   assign frames_dropped = dropped_r;
   assign overflow       = ovf_flag_r;
`else
   assign frames_passed  = 16'd0;
   assign frames_dropped = 16'd0;
   assign overflow       = 1'b0;
`endif

endmodule

// File: tb/tb_eth_rx_frame_filter.sv
// Directed bench for eth_rx_frame_filter: a default-size instance (a) and a
// 64-byte-buffer instance (b) share the input byte stream; sel steers tvalid.
module tb_eth_rx_frame_filter;

`ifdef RX_FILTER_STATS_EN
   localparam int STATS = 1;
`else
   localparam int STATS = 0;
`endif

   logic        clk, rst, promisc, sel;
   logic [7:0]  s_tdata;
   logic        s_tvalid, s_tlast, s_tuser;
   logic        s_valid_a, s_valid_b;
   logic        s_tready_a, s_tready_b;
   logic [7:0]  m_tdata_a, m_tdata_b;
   logic        m_tvalid_a, m_tvalid_b, m_tlast_a, m_tlast_b;
   logic        m_tready_a, m_tready_b;
   logic [15:0] passed_a, dropped_a, passed_b, dropped_b;
   logic        ovf_a, ovf_b;

   int errors = 0;
   int checks = 0;
   int stall_err = 0;
   logic       stall_pend = 1'b0;
   logic [7:0] stall_data = 8'h00;
   logic       stall_last = 1'b0;

   logic [7:0] fbuf [0:127];
   logic [8:0] out_q[$], out_q_b[$], exp_q[$], exp_q_b[$];

   assign s_valid_a = s_tvalid & ~sel;
   assign s_valid_b = s_tvalid & sel;

   eth_rx_frame_filter dut_a (
      .gtx_clk_bufg(clk), .gtx_reset(rst), .promisc_en(promisc),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_valid_a), .s_axis_tlast(s_tlast),
      .s_axis_tuser(s_tuser), .s_axis_tready(s_tready_a),
      .m_axis_tdata(m_tdata_a), .m_axis_tvalid(m_tvalid_a), .m_axis_tlast(m_tlast_a),
      .m_axis_tready(m_tready_a), .frames_passed(passed_a),
      .frames_dropped(dropped_a), .overflow(ovf_a));

   eth_rx_frame_filter #(.BUF_ADDR_WIDTH(6)) dut_b (
      .gtx_clk_bufg(clk), .gtx_reset(rst), .promisc_en(promisc),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_valid_b), .s_axis_tlast(s_tlast),
      .s_axis_tuser(s_tuser), .s_axis_tready(s_tready_b),
      .m_axis_tdata(m_tdata_b), .m_axis_tvalid(m_tvalid_b), .m_axis_tlast(m_tlast_b),
      .m_axis_tready(m_tready_b), .frames_passed(passed_b),
      .frames_dropped(dropped_b), .overflow(ovf_b));

   always #5 clk = ~clk;

   // collect handshaken output bytes and watch output stability during stalls
   always @(negedge clk) begin
      if (m_tvalid_a && m_tready_a) out_q.push_back({m_tlast_a, m_tdata_a});
      if (m_tvalid_b && m_tready_b) out_q_b.push_back({m_tlast_b, m_tdata_b});
      if (stall_pend && (!m_tvalid_a || m_tdata_a != stall_data || m_tlast_a != stall_last))
         stall_err++;
      stall_pend = m_tvalid_a && !m_tready_a;
      stall_data = m_tdata_a;
      stall_last = m_tlast_a;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // kind 0 = our MAC, 1 = foreign MAC, 2 = broadcast
   task automatic build(input int kind, input int len, input logic [7:0] seed);
      logic [47:0] dst;
      logic [47:0] src;
      case (kind)
         0:       dst = 48'h5a0102030405;
         1:       dst = 48'h985aebdb066f;
         default: dst = 48'hffffffffffff;
      endcase
      src = 48'h020000000001;
      for (int i = 0; i < len; i++) begin
         if (i < 6)       fbuf[i] = dst[47-8*i -: 8];
         else if (i < 12) fbuf[i] = src[47-8*(i-6) -: 8];
         else             fbuf[i] = seed + 8'(i);
      end
   endtask

   // drive fbuf as back-to-back beats; returns right after driving the last beat
   task automatic send(input int len, input int err_idx, input bit fwd);
      for (int i = 0; i < len; i++) begin
         @(posedge clk); #1;
         s_tvalid = 1'b1;
         s_tdata  = fbuf[i];
         s_tlast  = (i == len - 1);
         s_tuser  = (i == err_idx);
         if (fwd) begin
            if (sel) exp_q_b.push_back({(i == len - 1), fbuf[i]});
            else     exp_q.push_back({(i == len - 1), fbuf[i]});
         end
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         s_tvalid = 1'b0;
         s_tlast  = 1'b0;
         s_tuser  = 1'b0;
      end
   endtask

   task automatic check_out(input string tag, input bit use_b);
      int waited;
      int n_out, n_exp, n;
      waited = 0;
      while (((use_b ? out_q_b.size() : out_q.size()) < (use_b ? exp_q_b.size() : exp_q.size()))
             && waited < 2000) begin
         @(posedge clk);
         waited++;
      end
      repeat (6) @(posedge clk);
      #1;
      n_out = use_b ? out_q_b.size() : out_q.size();
      n_exp = use_b ? exp_q_b.size() : exp_q.size();
      chk({tag, "_count"}, n_out, n_exp);
      n = (n_out < n_exp) ? n_out : n_exp;
      for (int i = 0; i < n; i++) begin
         if (use_b) chk({tag, "_byte"}, out_q_b[i], exp_q_b[i]);
         else       chk({tag, "_byte"}, out_q[i], exp_q[i]);
      end
      out_q.delete(); exp_q.delete(); out_q_b.delete(); exp_q_b.delete();
   endtask

   initial begin
      clk = 1'b0; rst = 1'b1; promisc = 1'b0; sel = 1'b0;
      s_tdata = 8'h00; s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
      m_tready_a = 1'b1; m_tready_b = 1'b0;
      #12;
      chk("rst_tvalid", m_tvalid_a, 1'b0);
      chk("rst_tdata", m_tdata_a, 8'h00);
      chk("rst_tlast", m_tlast_a, 1'b0);
      chk("rst_tready", s_tready_a, 1'b1);
      chk("rst_passed", passed_a, 16'd0);
      chk("rst_dropped", dropped_a, 16'd0);
      chk("rst_overflow", ovf_a, 1'b0);
      rst = 1'b0;
      idle(3);

      // good 38-byte frame and its latency
      build(0, 38, 8'h10);
      send(38, -1, 1'b1);
      idle(1);
      chk("lat_e0_tvalid", m_tvalid_a, 1'b0);
      @(posedge clk); #1;
      chk("lat_e1_tvalid", m_tvalid_a, 1'b0);
      @(posedge clk); #1;
      chk("lat_e2_tvalid", m_tvalid_a, 1'b1);
      chk("lat_e2_tdata", m_tdata_a, 8'h5a);
      check_out("good38", 1'b0);
      chk("good38_passed", passed_a, 16'(STATS * 1));

      // foreign destination: dropped, then accepted in promiscuous mode
      build(1, 38, 8'h40);
      send(38, -1, 1'b0);
      idle(1);
      check_out("foreign", 1'b0);
      chk("foreign_dropped", dropped_a, 16'(STATS * 1));
      promisc = 1'b1;
      send(38, -1, 1'b1);
      idle(1);
      check_out("promisc", 1'b0);
      promisc = 1'b0;
      chk("promisc_passed", passed_a, 16'(STATS * 2));

      // broadcast destination accepted
      build(2, 20, 8'h70);
      send(20, -1, 1'b1);
      idle(1);
      check_out("bcast", 1'b0);

      // error strobe on byte 20 drops the frame; the next one is intact
      build(0, 38, 8'h90);
      send(38, 19, 1'b0);
      build(0, 38, 8'hA0);
      send(38, -1, 1'b1);
      idle(1);
      check_out("after_err", 1'b0);
      chk("err_dropped", dropped_a, 16'(STATS * 2));

      // runt boundary: 13 bytes dropped, 14 bytes forwarded
      build(0, 13, 8'hB0);
      send(13, -1, 1'b0);
      idle(1);
      build(0, 14, 8'hC0);
      send(14, -1, 1'b1);
      idle(1);
      check_out("runt", 1'b0);
      chk("runt_dropped", dropped_a, 16'(STATS * 3));
      chk("runt_passed", passed_a, 16'(STATS * 5));

      // two back-to-back frames drained with tready toggling every cycle
      m_tready_a = 1'b0;
      build(0, 38, 8'h20);
      send(38, -1, 1'b1);
      build(0, 38, 8'h60);
      send(38, -1, 1'b1);
      idle(1);
      for (int k = 0; k < 400 && out_q.size() < 76; k++) begin
         @(posedge clk); #1;
         m_tready_a = ~m_tready_a;
      end
      m_tready_a = 1'b1;
      check_out("toggle", 1'b0);
      chk("toggle_stable", stall_err, 0);
      chk("toggle_passed", passed_a, 16'(STATS * 7));

      // small buffer: second 40-byte frame overflows while output is stalled
      sel = 1'b1;
      idle(1);
      build(0, 40, 8'h33);
      send(40, -1, 1'b1);
      build(0, 40, 8'h55);
      send(40, -1, 1'b0);
      idle(2);
      chk("ovf_flag", ovf_b, 1'(STATS));
      chk("ovf_dropped", dropped_b, 16'(STATS * 1));
      chk("ovf_passed", passed_b, 16'(STATS * 1));
      m_tready_b = 1'b1;
      check_out("ovf_first", 1'b1);
      sel = 1'b0;
      idle(1);

      // reset at output byte 10 while a new input frame is arriving
      build(0, 38, 8'h11);
      send(38, -1, 1'b0);
      build(0, 38, 8'h77);
      for (int i = 0; i < 38; i++) begin
         @(posedge clk); #1;
         s_tvalid = 1'b1;
         s_tdata  = fbuf[i];
         s_tlast  = (i == 37);
         s_tuser  = 1'b0;
         if (i == 12) begin
            chk("pre_rst_bytes", out_q.size(), 10);
            rst = 1'b1;
            #1;
            chk("async_tvalid", m_tvalid_a, 1'b0);
            chk("async_tdata", m_tdata_a, 8'h00);
            chk("async_tlast", m_tlast_a, 1'b0);
            chk("async_passed", passed_a, 16'd0);
            out_q.delete();
            exp_q.delete();
         end
         if (i == 15) rst = 1'b0;
      end
      idle(2);
      check_out("sync_discard", 1'b0);
      build(0, 38, 8'hE0);
      send(38, -1, 1'b1);
      idle(1);
      check_out("post_rst", 1'b0);
      chk("post_rst_passed", passed_a, 16'(STATS * 1));
      chk("post_rst_dropped", dropped_a, 16'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
